// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions for the memory stage.
//   - load/store opcode constants (IR[31:26])
//   - NOP encoding (sll $0,$0,0)
//   - default data-memory depth in 32-bit words
//   - access-size enum and a small decoder that maps an opcode to
//     its load/store class, access size and signedness
package mips_defs;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int DM_WORDS = 1024;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  is_load;
        logic  is_store;
        size_t size;
        logic  is_signed;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t d;
        d.is_load   = 1'b0;
        d.is_store  = 1'b0;
        d.size      = SIZE_WORD;
        d.is_signed = 1'b0;
        case (op)
            OP_LW:  begin d.is_load  = 1'b1; d.size = SIZE_WORD; end
            OP_LB:  begin d.is_load  = 1'b1; d.size = SIZE_BYTE; d.is_signed = 1'b1; end
            OP_LBU: begin d.is_load  = 1'b1; d.size = SIZE_BYTE; end
            OP_LH:  begin d.is_load  = 1'b1; d.size = SIZE_HALF; d.is_signed = 1'b1; end
            OP_LHU: begin d.is_load  = 1'b1; d.size = SIZE_HALF; end
            OP_SW:  begin d.is_store = 1'b1; d.size = SIZE_WORD; end
            OP_SB:  begin d.is_store = 1'b1; d.size = SIZE_BYTE; end
            OP_SH:  begin d.is_store = 1'b1; d.size = SIZE_HALF; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_dm_byte_lane.sv
// dm_byte_lane: combinational byte/halfword lane logic for the data memory.
// Ports:
//   word       in  32  current contents of the addressed memory word
//   offset     in  2   byte offset within the word (address bits [1:0])
//   size       in      access size (byte / half / word)
//   is_signed  in  1   sign-extend narrow loads when set
//   store_data in  32  store source; only the low byte/half is used for sb/sh
//   load_data  out 32  selected and extended load value
//   merged     out 32  word after the store is merged into it
// Little-endian: byte 0 is word[7:0]. Word accesses ignore the offset.
module dm_byte_lane
    import mips_defs::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        is_signed,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: ;
        endcase
        // halfword lane chosen by address bit 1 only
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            default:   load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SIZE_BYTE: begin
                case (offset)
                    2'd0: merged[7:0]   = store_data[7:0];
                    2'd1: merged[15:8]  = store_data[7:0];
                    2'd2: merged[23:16] = store_data[7:0];
                    2'd3: merged[31:24] = store_data[7:0];
                    default: ;
                endcase
            end
            SIZE_HALF: begin
                if (offset[1]) merged[31:16] = store_data[15:0];
                else           merged[15:0]  = store_data[15:0];
            end
            default: merged = store_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM pipeline register and a DM_WORDS x 32 data memory,
// performs byte/half/word loads (combinational read) and stores
// (read-modify-write, committed at the rising edge ending the M cycle).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush_M                     insert a bubble instead of the EX values
//   IR_E, PC4_E, ALUout_E, RT_E values leaving the execute stage
//   RegWrite_W, A3_W, WD_W      writeback stage, used to forward store data
//   IR_M, PC4_M, ALUout_M       registered values for writeback
//   DMout_M                     extended load data, 0 for non-loads
//   dm_we, dm_addr, dm_wdata    store trace: enable, byte address, merged word
module mem_stage
    import mips_defs::*;
#(
    parameter int DM_WORDS = mips_defs::DM_WORDS,
    parameter int ADDR_LSB = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_M,
    input  logic [31:0] IR_E,
    input  logic [31:0] PC4_E,
    input  logic [31:0] ALUout_E,
    input  logic [31:0] RT_E,
    input  logic        RegWrite_W,
    input  logic [4:0]  A3_W,
    input  logic [31:0] WD_W,
    output logic [31:0] IR_M,
    output logic [31:0] PC4_M,
    output logic [31:0] ALUout_M,
    output logic [31:0] DMout_M,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata
);

    localparam int IDX_W = $clog2(DM_WORDS);

    logic [31:0]      rt_m;
    logic [31:0]      mem [DM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [31:0]      store_data;
    logic [31:0]      load_data;
    logic [31:0]      merged;
    mem_op_t          op_m;

    // EX/MEM pipeline register; a flush turns the slot into a NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IR_M     <= NOP;
            PC4_M    <= 32'h0;
            ALUout_M <= 32'h0;
            rt_m     <= 32'h0;
        end else if (flush_M) begin
            IR_M     <= NOP;
            PC4_M    <= 32'h0;
            ALUout_M <= 32'h0;
            rt_m     <= RT_E;
        end else begin
            IR_M     <= IR_E;
            PC4_M    <= PC4_E;
            ALUout_M <= ALUout_E;
            rt_m     <= RT_E;
        end
    end

    assign op_m = decode_op(IR_M[31:26]);

    // Address bits above the memory depth are dropped, so accesses wrap.
    assign word_idx = ALUout_M[ADDR_LSB +: IDX_W];
    assign rd_word  = mem[word_idx];

    // A load in W writing the register a store in M reads: take WD_W.
    // $0 is never forwarded since it always reads as zero.
    always_comb begin
        store_data = rt_m;
        if (RegWrite_W && (A3_W != 5'd0) && (A3_W == IR_M[20:16]))
            store_data = WD_W;
    end

    dm_byte_lane u_lane (
        .word       (rd_word),
        .offset     (ALUout_M[1:0]),
        .size       (op_m.size),
        .is_signed  (op_m.is_signed),
        .store_data (store_data),
        .load_data  (load_data),
        .merged     (merged)
    );

    // Memory array; reset clears every word and also cancels a store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'h0;
        end else if (op_m.is_store) begin
            mem[word_idx] <= merged;
        end
    end

    assign DMout_M  = op_m.is_load ? load_data : 32'h0;
    assign dm_we    = op_m.is_store;
    assign dm_addr  = ALUout_M;
    assign dm_wdata = merged;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and a 4 KiB data memory.
- Executes word, halfword and byte loads and stores, with forwarding of store data from writeback.
- Hands the instruction, PC+4, ALU result and load data to the writeback stage.

Parameters:
- DM_WORDS, 1024, depth of the data memory in 32-bit words (address bits [11:2]).
- ADDR_LSB, 2, lowest word-index bit of the byte address.

Ports:
- clk  in  1  pipeline clock, rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- flush_M  in  1  synchronous bubble insert; the register loads NOP instead of EX values.
- IR_E  in  32  instruction leaving the execute stage.
- PC4_E  in  32  PC+4 of that instruction.
- ALUout_E  in  32  ALU result: effective address for loads/stores, otherwise the result.
- RT_E  in  32  rt operand already forwarded at E; store data.
- RegWrite_W  in  1  writeback stage writes the register file this cycle.
- A3_W  in  5  writeback destination register.
- WD_W  in  32  writeback data.
- IR_M  out  32  registered instruction.
- PC4_M  out  32  registered PC+4.
- ALUout_M  out  32  registered ALU result.
- DMout_M  out  32  load result after byte/halfword select and sign/zero extension; 0 for non-loads.
- dm_we  out  1  store commits at next rising edge (debug/trace).
- dm_addr  out  32  byte address of the access; equals ALUout_M.
- dm_wdata  out  32  merged word written to memory (debug/trace).

Behaviour:
- Reset is asynchronous, active-low, and fixed: one clk, rst_n. While rst_n=0:
  - IR_M, PC4_M, ALUout_M and the internal RT_M are 0.
  - Every memory word is 0.
  - dm_we=0, DMout_M=0.
- Release of rst_n is synchronised by the user; the first rising edge after release loads the EX values.
- Pipeline register:
  - Each rising edge, the {IR,PC4,ALUout,RT} E values load into the M registers.
  - With flush_M=1, IR_M loads 0 (sll $0 = NOP), PC4_M and ALUout_M load 0, and no store occurs for that slot.
  - No stall input: the MEM stage never stalls.
- Decode uses IR_M[31:26]:
  - lw=0x23, lb=0x20, lbu=0x24, lh=0x21, lhu=0x25.
  - sw=0x2B, sb=0x28, sh=0x29.
  - Any other opcode is neither load nor store.
- Store-data forward: if RegWrite_W=1, A3_W!=0 and A3_W==IR_M[20:16], the store data is WD_W; otherwise it is RT_M. This covers a load at W followed by a store at M.
- Word index is ALUout_M[11:2]. Address bits above 11 are ignored (wrap within 4 KiB). Offset is ALUout_M[1:0].
- Read is combinational from the current memory contents. Load latency is 0 cycles within M; data is visible in DMout_M in the same cycle IR_M holds the load.
- Load data selection:
  - lw returns the whole word; the offset is ignored (alignment is not checked, low 2 bits are treated as 0).
  - lh/lhu select the half at bit ALUout_M[1]: [15:0] when the bit is 0, [31:16] when it is 1. lh sign-extends, lhu zero-extends.
  - lb/lbu select byte ALUout_M[1:0], little-endian (byte 0 = [7:0]). lb sign-extends, lbu zero-extends.
- Store merging is read-modify-write of the current word:
  - sw replaces all 32 bits.
  - sh replaces the half chosen by ALUout_M[1].
  - sb replaces the byte chosen by ALUout_M[1:0].
  - The merged word is written at the rising edge that ends the store's M cycle. dm_we=1 during that cycle.
- Store followed by a load to the same word on the next cycle: the load sees the new value.
- The write occurs before the next IR_M is registered. No bypass is required because the write and the read are in different cycles.
- Reset asserted mid-store: the write is suppressed and the memory is cleared.

Decomposition:
- Shared package mips_defs holds:
  - the opcode constants above (OP_LW … OP_SH);
  - the NOP constant 32'h0;
  - DM_WORDS.
- One sub-module, dm_byte_lane: pure combinational.
  - Inputs: word, offset, size, signedness.
  - Outputs: extended load result, plus the merged store word.
- mem_stage instantiates dm_byte_lane and owns the registers and the memory array.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → IR_M=0, ALUout_M=0, DMout_M=0; lw from address 0x0 returns 0.
- sw then lw: store RT_E=0xDEADBEEF to 0x10, then lw 0x10 → DMout_M=0xDEADBEEF; dm_we=1 only in the sw cycle.
- Byte/half extension, after sw 0x80FF7F01 at 0x20:
  - lb 0x23 → 0xFFFFFF80; lbu 0x23 → 0x00000080;
  - lh 0x20 → 0x00007F01; lh 0x22 → 0xFFFF80FF; lhu 0x22 → 0x000080FF.
- Merging: sw 0x11223344 to 0x30, then sb RT=0xAA to 0x31, then sh RT=0xBEEF to 0x32 → lw 0x30 gives 0xBEEFAA44.
- Forwarding:
  - IR_M = sw $5, with RT_M=0x1 and the W stage holding RegWrite_W=1, A3_W=5, WD_W=0x12345678 → memory gets 0x12345678.
  - Same case with A3_W=0 → memory gets RT_M.
- Flush/reset: a sw in E with flush_M=1 → no memory change, IR_M=0. Pull rst_n low during a store's M cycle → the word reads 0 after release.
